// File: rtl/uart_pkt_tx_if.sv
// Start/busy/done handshake between the control logic and the packet transmitter.
// The master side issues a request and a payload. The slave side reports busy and done.
interface uart_pkt_tx_if;
    logic        tx_en;
    logic [63:0] tx_data;
    logic        tx_busy;
    logic        tx_done;

    modport master (output tx_en, tx_data, input  tx_busy, tx_done);
    modport slave  (input  tx_en, tx_data, output tx_busy, tx_done);
endinterface

// File: rtl/uart_pkt_tx.sv
// Sends a 64-bit word as a 10-byte 8N1 frame: header, 8 data bytes (LSB first), XOR checksum.
// The start bit is driven on the accept edge and the frame lasts 100*BPS_CNT cycles. Requests are ignored while busy.
module uart_pkt_tx #(
    parameter int          CLK_FREQ = 50000000,
    parameter int          UART_BPS = 115200,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    uart_pkt_tx_if.slave    tx_if,
    output logic            uart_txd
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [3:0]         byte_q, byte_d;
    logic [7:0]         shf_q, shf_d;
    logic [63:0]        data_q, data_d;
    logic [7:0]         chk_q, chk_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end;

    function automatic logic [7:0] xor_bytes(input logic [63:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) x = x ^ w[8*i +: 8];
        return x;
    endfunction

    // Byte indices 1..8 are payload bytes. Index 9 is the checksum.
    function automatic logic [7:0] pick_byte(input logic [3:0] idx, input logic [63:0] w,
                                             input logic [7:0] c);
        logic [7:0] b;
        b = c;
        for (int i = 0; i < 8; i++) begin
            if (idx == 4'(i + 1)) b = w[8*i +: 8];
        end
        return b;
    endfunction

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shf_d   = shf_q;
        data_d  = data_q;
        chk_d   = chk_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (tx_if.tx_en && !busy_q) begin
                    data_d  = tx_if.tx_data;
                    chk_d   = xor_bytes(tx_if.tx_data);
                    shf_d   = HEADER;
                    bit_d   = '0;
                    byte_d  = '0;
                    busy_d  = 1'b1;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_d   = shf_q[0];
                    shf_d   = {1'b0, shf_q[7:1]};
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        txd_d = shf_q[0];
                        shf_d = {1'b0, shf_q[7:1]};
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == 4'd9) begin
                        // Done and busy drop together, so a request held high is accepted on the next edge.
                        byte_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        shf_d   = pick_byte(byte_q + 4'd1, data_q, chk_q);
                        txd_d   = 1'b0;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shf_q   <= '0;
            data_q  <= '0;
            chk_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shf_q   <= shf_d;
            data_q  <= data_d;
            chk_q   <= chk_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_if.tx_busy = busy_q;
    assign tx_if.tx_done = done_q;
    assign uart_txd      = txd_q;

endmodule
